muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 34 cycles per operation, registered writeback request.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wb_addr,
  output logic        wb_we
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t st, st_n;
  logic [4:0] cnt, rd_q;
  logic [2:0] f_q;
  logic [31:0] a_q, b_q, a_orig, rem_q, a_mag, b_mag, fix_val, quo, rmd;
  logic [63:0] acc, prod;
  logic [32:0] t, rs, diff;
  logic sa, sb, neg_q, neg_r, div0, ovf;
  assign wb_addr = rd_q;
  always_comb begin
    sa = (funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11) & rs1_val[31];
    sb = (funct3[2] ? ~funct3[0] : ~funct3[1]) & rs2_val[31];
    a_mag = sa ? -rs1_val : rs1_val;
    b_mag = sb ? -rs2_val : rs2_val;
    t = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
    rs = {rem_q, acc[31]};
    diff = rs - {1'b0, b_q};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[31:0] : acc[31:0];
    rmd = neg_r ? -rem_q : rem_q;
    fix_val = !f_q[2] ? (f_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32])
            : div0 ? (f_q[1] ? a_orig : 32'hFFFF_FFFF)
            : ovf ? (f_q[1] ? 32'd0 : 32'h8000_0000)
            : f_q[1] ? rmd : quo;
    st_n = (st == IDLE && start) ? CALC
         : (st == CALC && cnt == 5'd31) ? FIX
         : (st == FIX) ? DONE
         : (st == DONE) ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {busy, done, wb_we, neg_q, neg_r, div0, ovf} <= '0;
      {cnt, rd_q, f_q} <= '0;
      {a_q, b_q, a_orig, rem_q, result} <= '0;
      acc <= '0;
    end else begin
      busy <= st_n != IDLE;
      done <= st_n == DONE;
      wb_we <= st_n == DONE && rd_q != 5'd0;
      if (st == IDLE && start) begin
        f_q <= funct3;
        rd_q <= rd;
        a_orig <= rs1_val;
        a_q <= a_mag;
        b_q <= b_mag;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        div0 <= rs2_val == 32'd0;
        ovf <= funct3[2] & ~funct3[0] & rs1_val == 32'h8000_0000 & rs2_val == 32'hFFFF_FFFF;
        acc <= {32'd0, funct3[2] ? a_mag : b_mag};
        rem_q <= '0;
        cnt <= '0;
      end else if (st == CALC) begin
        cnt <= cnt + 5'd1;
        if (f_q[2]) begin
          rem_q <= diff[32] ? rs[31:0] : diff[31:0];
          acc <= {acc[63:32], acc[30:0], ~diff[32]};
        end else acc <= {t, acc[31:1]};
      end else if (st == FIX) result <= fix_val;
    end
  end
endmodule
